// File: rtl/params_pkg.sv
// Shared core-wide widths used as defaults by the back-end blocks.
package params_pkg;
  localparam int unsigned ROB_ENTRY_WIDTH = 6;
  localparam int unsigned DATA_WIDTH      = 32;
endpackage

// File: rtl/completion_arbiter_if.sv
// Execution-unit result ports plus the single completion channel toward the ROB.
interface completion_arbiter_if #(
  parameter int unsigned N_PORTS         = 3,
  parameter int unsigned ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
  parameter int unsigned DATA_WIDTH      = params_pkg::DATA_WIDTH
);
  logic [N_PORTS-1:0]                      unit_valid_i;
  logic [N_PORTS-1:0][ROB_ENTRY_WIDTH-1:0] unit_idx_i;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]      unit_data_i;
  logic [N_PORTS-1:0]                      unit_excp_i;
  logic [N_PORTS-1:0]                      unit_ready_o;
  logic                                    instr_complete_valid_o;
  logic [ROB_ENTRY_WIDTH-1:0]              instr_complete_idx_o;
  logic [DATA_WIDTH-1:0]                   instr_complete_data_o;
  logic                                    instr_excp_valid_o;
  logic                                    pending_o;

  // Arbiter side
  modport slave (
    input  unit_valid_i, unit_idx_i, unit_data_i, unit_excp_i,
    output unit_ready_o, instr_complete_valid_o, instr_complete_idx_o,
           instr_complete_data_o, instr_excp_valid_o, pending_o
  );

  // Execution units / ROB side
  modport master (
    output unit_valid_i, unit_idx_i, unit_data_i, unit_excp_i,
    input  unit_ready_o, instr_complete_valid_o, instr_complete_idx_o,
           instr_complete_data_o, instr_excp_valid_o, pending_o
  );
endinterface

// File: rtl/completion_arbiter.sv
// Buffers execution-unit results in per-port FIFOs and retires at most one per
// cycle to the ROB using round-robin arbitration.
module completion_arbiter #(
  parameter int unsigned N_PORTS         = 3,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
  parameter int unsigned DATA_WIDTH      = params_pkg::DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  completion_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [ROB_ENTRY_WIDTH-1:0] idx_mem  [N_PORTS][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      data_mem [N_PORTS][FIFO_DEPTH];
  logic                       excp_mem [N_PORTS][FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q [N_PORTS];
  logic [PTR_W-1:0] rd_ptr_q [N_PORTS];
  logic [CNT_W-1:0] count_q  [N_PORTS];
  logic [RR_W-1:0]  rr_ptr_q;

  logic [N_PORTS-1:0] ready_c;
  logic [N_PORTS-1:0] nonempty_c;
  logic [N_PORTS-1:0] push_c;
  logic [N_PORTS-1:0] pop_c;
  logic [RR_W-1:0]    cand_c [N_PORTS];
  logic               grant_any_c;
  logic [RR_W-1:0]    grant_idx_c;
  logic [PTR_W-1:0]   head_ptr_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      ready_c[k]    = count_q[k] < CNT_W'(FIFO_DEPTH);
      nonempty_c[k] = count_q[k] != '0;
    end
  end

  assign push_c = bus.unit_valid_i & ready_c;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      cand_c[i] = RR_W'((32'(rr_ptr_q) + 32'(i)) % N_PORTS);
    end
  end

  // First non-empty port at or after rr_ptr wins.
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    pop_c       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!grant_any_c && nonempty_c[cand_c[i]]) begin
        grant_any_c = 1'b1;
        grant_idx_c = cand_c[i];
      end
    end
    if (grant_any_c) begin
      pop_c[grant_idx_c] = 1'b1;
    end
  end

  assign head_ptr_c = rd_ptr_q[grant_idx_c];

  assign bus.unit_ready_o           = ready_c;
  assign bus.pending_o              = |nonempty_c;
  assign bus.instr_complete_valid_o = grant_any_c;
  assign bus.instr_complete_idx_o   = grant_any_c ? idx_mem[grant_idx_c][head_ptr_c] : '0;
  assign bus.instr_complete_data_o  = grant_any_c ? data_mem[grant_idx_c][head_ptr_c] : '0;
  assign bus.instr_excp_valid_o     = grant_any_c ? excp_mem[grant_idx_c][head_ptr_c] : 1'b0;

  // Storage is not reset; counts define which slots are live.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_PORTS; k++) begin
      if (push_c[k]) begin
        idx_mem[k][wr_ptr_q[k]]  <= bus.unit_idx_i[k];
        data_mem[k][wr_ptr_q[k]] <= bus.unit_data_i[k];
        excp_mem[k][wr_ptr_q[k]] <= bus.unit_excp_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
    end else begin
      if (grant_any_c) begin
        rr_ptr_q <= (grant_idx_c == RR_W'(N_PORTS - 1)) ? '0 : grant_idx_c + RR_W'(1);
      end
      for (int k = 0; k < N_PORTS; k++) begin
        if (push_c[k]) begin
          wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
        end
        if (pop_c[k]) begin
          rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
        end
        if (push_c[k] && !pop_c[k]) begin
          count_q[k] <= count_q[k] + CNT_W'(1);
        end else if (!push_c[k] && pop_c[k]) begin
          count_q[k] <= count_q[k] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_completion_arbiter.sv
// Self-checking bench for completion_arbiter: directed table, corner sequences,
// fairness run and randomized traffic against a queue-based reference model.
module tb_completion_arbiter;
  localparam int unsigned NP    = 3;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned IW    = 6;
  localparam int unsigned DW    = 32;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          ex;
  } ent_t;

  typedef struct {
    logic [NP-1:0] v;
    ent_t          e [NP];
    logic          cv;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          ex;
    logic [NP-1:0] rdy;
    logic          pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  completion_arbiter_if #(.N_PORTS(NP), .ROB_ENTRY_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  completion_arbiter #(
    .N_PORTS(NP), .FIFO_DEPTH(DEPTH), .ROB_ENTRY_WIDTH(IW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one queue per port plus the round-robin start port.
  ent_t mq [NP][$];
  int   m_rr;

  logic [NP-1:0] d_v;
  ent_t          d_e [NP];
  logic          d_rst;

  int            grant;
  int            pre_sz [NP];
  logic [NP-1:0] exp_rdy;
  logic          a_cv;
  logic [IW-1:0] a_idx;
  logic [DW-1:0] a_data;
  logic          a_ex;
  logic [NP-1:0] a_rdy;
  logic          a_pend;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic ent_t mkent(input int idx, input logic [DW-1:0] data, input logic ex);
    ent_t e;
    e.idx  = IW'(idx);
    e.data = data;
    e.ex   = ex;
    return e;
  endfunction

  task automatic set_idle();
    d_rst = 1'b0;
    d_v   = '0;
    for (int k = 0; k < NP; k++) d_e[k] = '0;
  endtask

  // One clock: drive at negedge, compare against the model, advance model at posedge.
  task automatic cycle();
    int   g;
    logic pend_exp;
    ent_t he;
    @(negedge clk);
    rst = d_rst;
    bus.unit_valid_i = d_v;
    for (int k = 0; k < NP; k++) begin
      bus.unit_idx_i[k]  = d_e[k].idx;
      bus.unit_data_i[k] = d_e[k].data;
      bus.unit_excp_i[k] = d_e[k].ex;
    end
    #1;
    g = -1;
    pend_exp = 1'b0;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_rr + i) % NP;
      if (g < 0 && mq[p].size() != 0) g = p;
    end
    for (int k = 0; k < NP; k++) begin
      pre_sz[k]  = mq[k].size();
      exp_rdy[k] = mq[k].size() < DEPTH;
      if (mq[k].size() != 0) pend_exp = 1'b1;
    end
    he = (g >= 0) ? mq[g][0] : '0;
    a_cv   = bus.instr_complete_valid_o;
    a_idx  = bus.instr_complete_idx_o;
    a_data = bus.instr_complete_data_o;
    a_ex   = bus.instr_excp_valid_o;
    a_rdy  = bus.unit_ready_o;
    a_pend = bus.pending_o;
    chk("m_valid", 32'(a_cv), 32'(g >= 0));
    chk("m_idx", 32'(a_idx), 32'(he.idx));
    chk("m_data", a_data, he.data);
    chk("m_excp", 32'(a_ex), 32'(he.ex));
    chk("m_ready", 32'(a_rdy), 32'(exp_rdy));
    chk("m_pending", 32'(a_pend), 32'(pend_exp));
    grant = g;
    @(posedge clk);
    if (d_rst) begin
      for (int k = 0; k < NP; k++) mq[k].delete();
      m_rr = 0;
    end else begin
      if (g >= 0) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % NP;
      end
      for (int k = 0; k < NP; k++)
        if (d_v[k] && exp_rdy[k]) mq[k].push_back(d_e[k]);
    end
  endtask

  task automatic add_row(input logic [NP-1:0] v, input ent_t e0, input ent_t e1, input ent_t e2,
                         input logic cv, input int idx, input logic [DW-1:0] data, input logic ex,
                         input logic [NP-1:0] rdy, input logic pend);
    vec_t r;
    r.v = v;
    r.e[0] = e0; r.e[1] = e1; r.e[2] = e2;
    r.cv = cv; r.idx = IW'(idx); r.data = data; r.ex = ex; r.rdy = rdy; r.pend = pend;
    tbl.push_back(r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ent_t z;
    ent_t p2q [$];
    logic [IW-1:0] p2_done [$];
    int   n0;
    logic saw_full;
    int   cnt [NP];
    int   last [NP];
    int   maxgap [NP];

    z = '0;
    rst = 1'b1;
    set_idle();
    bus.unit_valid_i = '0;
    bus.unit_idx_i   = '0;
    bus.unit_data_i  = '0;
    bus.unit_excp_i  = '0;
    for (int k = 0; k < NP; k++) mq[k].delete();
    m_rr = 0;
    repeat (2) @(posedge clk);

    // Round-robin from reset, exception pass-through, then single result on port1.
    add_row(3'b111, mkent(1, 32'h100, 0), mkent(2, 32'h200, 0), mkent(3, 32'h300, 0), 0, 0, 0, 0, 3'b111, 0);
    add_row(3'b000, z, z, z, 1, 1, 32'h100, 0, 3'b111, 1);
    add_row(3'b000, z, z, z, 1, 2, 32'h200, 0, 3'b111, 1);
    add_row(3'b000, z, z, z, 1, 3, 32'h300, 0, 3'b111, 1);
    add_row(3'b111, mkent(7, 32'h700, 1), mkent(8, 32'h800, 0), mkent(9, 32'h900, 1), 0, 0, 0, 0, 3'b111, 0);
    add_row(3'b000, z, z, z, 1, 7, 32'h700, 1, 3'b111, 1);
    add_row(3'b000, z, z, z, 1, 8, 32'h800, 0, 3'b111, 1);
    add_row(3'b000, z, z, z, 1, 9, 32'h900, 1, 3'b111, 1);
    add_row(3'b010, z, mkent(5, 32'hDEAD, 0), z, 0, 0, 0, 0, 3'b111, 0);
    add_row(3'b000, z, z, z, 1, 5, 32'hDEAD, 0, 3'b111, 1);
    add_row(3'b000, z, z, z, 0, 0, 0, 0, 3'b111, 0);

    foreach (tbl[r]) begin
      d_rst = 1'b0;
      d_v   = tbl[r].v;
      for (int k = 0; k < NP; k++) d_e[k] = tbl[r].e[k];
      cycle();
      chk($sformatf("tbl%0d_valid", r), 32'(a_cv), 32'(tbl[r].cv));
      chk($sformatf("tbl%0d_idx", r), 32'(a_idx), 32'(tbl[r].idx));
      chk($sformatf("tbl%0d_data", r), a_data, tbl[r].data);
      chk($sformatf("tbl%0d_excp", r), 32'(a_ex), 32'(tbl[r].ex));
      chk($sformatf("tbl%0d_ready", r), 32'(a_rdy), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_pending", r), 32'(a_pend), 32'(tbl[r].pend));
    end

    // Backpressure: port2 fills while port0 streams; third entry waits for ready.
    set_idle(); d_rst = 1'b1; cycle(); set_idle();
    p2q.push_back(mkent(40, 32'hA1, 0));
    p2q.push_back(mkent(41, 32'hA2, 1));
    p2q.push_back(mkent(42, 32'hA3, 0));
    n0 = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 30 && (p2q.size() != 0 || mq[2].size() != 0); c++) begin
      d_v[0] = 1'b1;
      d_e[0] = mkent(n0 % 32, 32'hB000 + 32'(n0), 0);
      d_v[1] = 1'b0;
      d_v[2] = p2q.size() != 0;
      d_e[2] = (p2q.size() != 0) ? p2q[0] : '0;
      cycle();
      if (pre_sz[2] == DEPTH) begin
        saw_full = 1'b1;
        chk("bp_ready2_low", 32'(a_rdy[2]), 32'(0));
      end
      if (a_cv && a_idx >= IW'(40)) p2_done.push_back(a_idx);
      if (d_v[0] && a_rdy[0]) n0++;
      if (d_v[2] && a_rdy[2]) void'(p2q.pop_front());
    end
    chk("bp_full_seen", 32'(saw_full), 32'(1));
    chk("bp_drained", 32'(p2q.size() + mq[2].size()), 32'(0));
    chk("bp_count", 32'(p2_done.size()), 32'(3));
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_order%0d", i), (p2_done.size() > i) ? 32'(p2_done[i]) : 32'hFFFF, 32'(40 + i));

    // Reset mid-stream with four entries buffered and pushes during the reset cycle.
    set_idle(); d_rst = 1'b1; cycle(); set_idle();
    d_v = 3'b111;
    for (int k = 0; k < NP; k++) d_e[k] = mkent(20 + k, 32'hC0 + 32'(k), 1);
    cycle();
    d_v = 3'b011;
    for (int k = 0; k < NP; k++) d_e[k] = mkent(24 + k, 32'hD0 + 32'(k), 0);
    cycle();
    d_rst = 1'b1; d_v = 3'b111;
    cycle();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("rst%0d_valid", i), 32'(a_cv), 32'(0));
      chk($sformatf("rst%0d_excp", i), 32'(a_ex), 32'(0));
      chk($sformatf("rst%0d_pending", i), 32'(a_pend), 32'(0));
      chk($sformatf("rst%0d_ready", i), 32'(a_rdy), 32'(3'b111));
    end

    // Fairness: every port offers a result every cycle; idx encodes the port.
    set_idle(); d_rst = 1'b1; cycle(); set_idle();
    for (int k = 0; k < NP; k++) begin cnt[k] = 0; last[k] = -1; maxgap[k] = 0; end
    for (int c = 0; c < 300; c++) begin
      d_v = 3'b111;
      for (int k = 0; k < NP; k++) d_e[k] = mkent(k, $urandom, 1'($urandom));
      cycle();
      if (a_cv && a_idx < IW'(NP)) begin
        int p;
        p = int'(a_idx);
        cnt[p]++;
        if (last[p] >= 0 && c - last[p] - 1 > maxgap[p]) maxgap[p] = c - last[p] - 1;
        last[p] = c;
      end
    end
    for (int k = 0; k < NP; k++) begin
      chk_range($sformatf("fair_cnt%0d", k), cnt[k], 99, 101);
      chk_range($sformatf("fair_gap%0d", k), maxgap[k], 0, 2);
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      d_rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NP; k++) begin
        d_v[k] = ($urandom_range(0, 99) < 30 + 20 * k);
        d_e[k] = mkent(int'($urandom_range(0, 63)), $urandom, 1'($urandom));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
